// File: rtl/cla_pkg.sv
// cla_pkg: shared definitions for the pipelined carry-lookahead adder.
//   - legal WIDTH / GROUP ranges and a legality predicate
//   - cla_pg_t: propagate/generate pair for one lookahead group
//   - cla_ngroups(): number of lookahead groups for a given WIDTH/GROUP
package cla_pkg;

    localparam int CLA_WIDTH_MIN = 4;
    localparam int CLA_WIDTH_MAX = 64;
    localparam int CLA_GROUP_MIN = 2;
    localparam int CLA_GROUP_MAX = 8;

    typedef struct packed {
        logic p;
        logic g;
    } cla_pg_t;

    function automatic int cla_ngroups(input int width, input int group);
        return width / group;
    endfunction

    function automatic bit cla_params_legal(input int width, input int group);
        return (width >= CLA_WIDTH_MIN) && (width <= CLA_WIDTH_MAX) &&
               (group >= CLA_GROUP_MIN) && (group <= CLA_GROUP_MAX) &&
               ((width % group) == 0);
    endfunction

endpackage

// File: rtl/cla_group_pg.sv
// cla_group_pg: GROUP-bit combinational lookahead block.
// Produces the group propagate/generate pair and, from a group carry-in,
// the carry into every bit of the group. All terms are flattened sums of
// products (no ripple through the group).
// Ports:
//   p_i     [GROUP-1:0]  per-bit propagate (a ^ b)
//   g_i     [GROUP-1:0]  per-bit generate  (a & b)
//   c_i                  carry into bit 0 of the group
//   grp_o                group {P, G}
//   carry_o [GROUP-1:0]  carry into each bit of the group (carry_o[0] = c_i)
module cla_group_pg
    import cla_pkg::*;
#(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] p_i,
    input  logic [GROUP-1:0] g_i,
    input  logic             c_i,
    output cla_pg_t          grp_o,
    output logic [GROUP-1:0] carry_o
);

    logic term;
    logic g_acc;
    logic c_acc;

    always_comb begin
        grp_o   = '0;
        carry_o = '0;
        term    = 1'b0;
        g_acc   = 1'b0;
        c_acc   = 1'b0;

        grp_o.p = &p_i;

        // G = g[k-1] | p[k-1]g[k-2] | ... | p[k-1..1]g[0]
        for (int k = 0; k < GROUP; k++) begin
            term = g_i[k];
            for (int m = k + 1; m < GROUP; m++) begin
                term = term & p_i[m];
            end
            g_acc = g_acc | term;
        end
        grp_o.g = g_acc;

        // Carry into bit i: c_i propagated through p[i-1..0], plus every
        // lower generate propagated up to bit i.
        for (int i = 0; i < GROUP; i++) begin
            c_acc = c_i;
            for (int m = 0; m < i; m++) begin
                c_acc = c_acc & p_i[m];
            end
            for (int k = 0; k < i; k++) begin
                term = g_i[k];
                for (int m = k + 1; m < i; m++) begin
                    term = term & p_i[m];
                end
                c_acc = c_acc | term;
            end
            carry_o[i] = c_acc;
        end
    end

endmodule

// File: rtl/cla_adder_pipe.sv
// cla_adder_pipe: three-stage pipelined carry-lookahead adder,
// sum = (a + b + ci) mod 2^WIDTH, co = carry out of bit WIDTH-1.
// Valid/ready handshake; the whole pipe advances together on
// adv = ~out_valid | out_ready and holds otherwise (bubbles are kept).
// Optional feature macro: CLA_PIPE_OVF_EN adds the signed-overflow output ovf.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready = adv)
//   a, b [WIDTH-1:0], ci  operands and carry-in
//   out_valid / out_ready result handshake
//   sum [WIDTH-1:0], co   result and carry-out, driven from stage-3 registers
//   ovf                   signed overflow (only with CLA_PIPE_OVF_EN)
module cla_adder_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co
`ifdef CLA_PIPE_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NG = cla_ngroups(WIDTH, GROUP);

    if (!cla_params_legal(WIDTH, GROUP)) begin : g_bad_params
        $error("cla_adder_pipe: illegal WIDTH/GROUP combination");
    end

    logic adv;

    // control
    logic vld_p1_q;
    logic vld_p2_q;
    logic vld_p3_q;

    // stage 0 (combinational, from operands)
    logic [WIDTH-1:0] p_p0;
    logic [WIDTH-1:0] g_p0;
    cla_pg_t [NG-1:0] grp_p0;
    logic [WIDTH-1:0] unused_carry_p0;

    // stage 1 registers
    logic [WIDTH-1:0] p_p1_q;
    logic [WIDTH-1:0] g_p1_q;
    logic [NG-1:0]    gp_p1_q;
    logic [NG-1:0]    gg_p1_q;
    logic             ci_p1_q;

    // stage 1 -> 2 second-level lookahead
    logic [NG:0]      gc_d;
    logic             term;
    logic             acc;

    // stage 2 registers
    logic [WIDTH-1:0] p_p2_q;
    logic [WIDTH-1:0] g_p2_q;
    logic [NG:0]      gc_p2_q;

    // stage 2 -> 3 in-group carries
    logic [WIDTH-1:0] carry_p2;
    cla_pg_t [NG-1:0] unused_grp_p2;
    logic [WIDTH-1:0] sum_d;
    logic             co_d;

    // stage 3 registers
    logic [WIDTH-1:0] sum_p3_q;
    logic             co_p3_q;

`ifdef CLA_PIPE_OVF_EN
    logic as_p1_q;
    logic bs_p1_q;
    logic as_p2_q;
    logic bs_p2_q;
    logic ovf_d;
    logic ovf_p3_q;
`endif

    assign adv       = ~vld_p3_q | out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_p3_q;
    assign sum       = sum_p3_q;
    assign co        = co_p3_q;
`ifdef CLA_PIPE_OVF_EN
    assign ovf       = ovf_p3_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            vld_p3_q <= 1'b0;
        end else if (adv) begin
            vld_p1_q <= in_valid;
            vld_p2_q <= vld_p1_q;
            vld_p3_q <= vld_p2_q;
        end
    end

    // ---- stage 1: bit and group propagate/generate ----
    assign p_p0 = a ^ b;
    assign g_p0 = a & b;

    for (genvar j = 0; j < NG; j++) begin : g_pg_p0
        cla_group_pg #(.GROUP(GROUP)) u_pg (
            .p_i     (p_p0[j*GROUP +: GROUP]),
            .g_i     (g_p0[j*GROUP +: GROUP]),
            .c_i     (1'b0),
            .grp_o   (grp_p0[j]),
            .carry_o (unused_carry_p0[j*GROUP +: GROUP])
        );
    end

    // Bit generates travel alongside p: stage 3 needs them to form the
    // in-group carries.
    always_ff @(posedge clk) begin
        if (adv) begin
            p_p1_q  <= p_p0;
            g_p1_q  <= g_p0;
            ci_p1_q <= ci;
            for (int j = 0; j < NG; j++) begin
                gp_p1_q[j] <= grp_p0[j].p;
                gg_p1_q[j] <= grp_p0[j].g;
            end
`ifdef CLA_PIPE_OVF_EN
            as_p1_q <= a[WIDTH-1];
            bs_p1_q <= b[WIDTH-1];
`endif
        end
    end

    // ---- stage 2: group carries, flattened across all groups ----
    // c[j+1] = ci&P[j..0] | G[0]&P[j..1] | ... | G[j]
    always_comb begin
        gc_d    = '0;
        term    = 1'b0;
        acc     = 1'b0;
        gc_d[0] = ci_p1_q;
        for (int j = 0; j < NG; j++) begin
            acc = ci_p1_q;
            for (int m = 0; m <= j; m++) begin
                acc = acc & gp_p1_q[m];
            end
            for (int k = 0; k <= j; k++) begin
                term = gg_p1_q[k];
                for (int m = k + 1; m <= j; m++) begin
                    term = term & gp_p1_q[m];
                end
                acc = acc | term;
            end
            gc_d[j+1] = acc;
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            p_p2_q  <= p_p1_q;
            g_p2_q  <= g_p1_q;
            gc_p2_q <= gc_d;
`ifdef CLA_PIPE_OVF_EN
            as_p2_q <= as_p1_q;
            bs_p2_q <= bs_p1_q;
`endif
        end
    end

    // ---- stage 3: in-group carries and final sum ----
    for (genvar j = 0; j < NG; j++) begin : g_pg_p2
        cla_group_pg #(.GROUP(GROUP)) u_pg (
            .p_i     (p_p2_q[j*GROUP +: GROUP]),
            .g_i     (g_p2_q[j*GROUP +: GROUP]),
            .c_i     (gc_p2_q[j]),
            .grp_o   (unused_grp_p2[j]),
            .carry_o (carry_p2[j*GROUP +: GROUP])
        );
    end

    assign sum_d = p_p2_q ^ carry_p2;
    assign co_d  = gc_p2_q[NG];
`ifdef CLA_PIPE_OVF_EN
    assign ovf_d = (as_p2_q ~^ bs_p2_q) & (sum_d[WIDTH-1] ^ as_p2_q);
`endif

    // Output registers are reset so the result bus reads zero in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_p3_q <= '0;
            co_p3_q  <= 1'b0;
`ifdef CLA_PIPE_OVF_EN
            ovf_p3_q <= 1'b0;
`endif
        end else if (adv) begin
            sum_p3_q <= sum_d;
            co_p3_q  <= co_d;
`ifdef CLA_PIPE_OVF_EN
            ovf_p3_q <= ovf_d;
`endif
        end
    end

endmodule

// File: tb/tb_cla_adder_pipe.sv
// tb_cla_adder_pipe: self-checking bench for cla_adder_pipe (WIDTH=16, GROUP=4)
// plus three parameter-sweep instances (8/2, 32/8, 64/4).
// The reference keeps three result slots that advance together whenever the
// output is empty or being consumed; each slot holds the arithmetic result of
// a + b + ci. Build with CLA_PIPE_OVF_EN defined to also check ovf.
module tb_cla_adder_pipe;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ci = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         co;
`ifdef CLA_PIPE_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cla_adder_pipe #(.WIDTH(W), .GROUP(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .co        (co)
`ifdef CLA_PIPE_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    // ---------------- parameter sweep instances ----------------
    logic        sw_valid = 1'b0;
    logic        sw8_rdy, sw32_rdy, sw64_rdy;
    logic        sw8_v, sw32_v, sw64_v;
    logic        sw8_co, sw32_co, sw64_co;
    logic [7:0]  sw8_sum;
    logic [31:0] sw32_sum;
    logic [63:0] sw64_sum;
`ifdef CLA_PIPE_OVF_EN
    logic        sw8_ovf, sw32_ovf, sw64_ovf;
`endif

    cla_adder_pipe #(.WIDTH(8), .GROUP(2)) u_sw8 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw8_rdy),
        .a('1), .b('0), .ci(1'b1), .out_valid(sw8_v), .out_ready(1'b1),
        .sum(sw8_sum), .co(sw8_co)
`ifdef CLA_PIPE_OVF_EN
        , .ovf(sw8_ovf)
`endif
    );

    cla_adder_pipe #(.WIDTH(32), .GROUP(8)) u_sw32 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw32_rdy),
        .a('1), .b('0), .ci(1'b1), .out_valid(sw32_v), .out_ready(1'b1),
        .sum(sw32_sum), .co(sw32_co)
`ifdef CLA_PIPE_OVF_EN
        , .ovf(sw32_ovf)
`endif
    );

    cla_adder_pipe #(.WIDTH(64), .GROUP(4)) u_sw64 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw64_rdy),
        .a('1), .b('0), .ci(1'b1), .out_valid(sw64_v), .out_ready(1'b1),
        .sum(sw64_sum), .co(sw64_co)
`ifdef CLA_PIPE_OVF_EN
        , .ovf(sw64_ovf)
`endif
    );

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    // Signed overflow: the true signed sum leaves the W-bit two's complement range.
    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                     input logic c);
        longint r;
        r = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
        return (r > ((longint'(1) << (W - 1)) - 1)) || (r < -(longint'(1) << (W - 1)));
    endfunction

    // ---------------- reference model and per-cycle compare ----------------
    logic         mv[3];
    logic [W:0]   md[3];
    logic         mo[3];

    initial begin
        logic adv_m;
        for (int i = 0; i < 3; i++) begin
            mv[i] = 1'b0; md[i] = '0; mo[i] = 1'b0;
        end
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                for (int i = 0; i < 3; i++) mv[i] = 1'b0;
                chk("rst_out_valid", 65'(out_valid), 65'(0));
                chk("rst_sum", 65'(sum), 65'(0));
                chk("rst_co", 65'(co), 65'(0));
`ifdef CLA_PIPE_OVF_EN
                chk("rst_ovf", 65'(ovf), 65'(0));
`endif
            end else begin
                adv_m = !mv[2] || out_ready;
                chk("in_ready", 65'(in_ready), 65'(adv_m));
                chk("out_valid", 65'(out_valid), 65'(mv[2]));
                if (mv[2]) begin
                    chk("sum", 65'(sum), 65'(md[2][W-1:0]));
                    chk("co", 65'(co), 65'(md[2][W]));
`ifdef CLA_PIPE_OVF_EN
                    chk("ovf", 65'(ovf), 65'(mo[2]));
`endif
                end
                if (adv_m) begin
                    mv[2] = mv[1]; md[2] = md[1]; mo[2] = mo[1];
                    mv[1] = mv[0]; md[1] = md[0]; mo[1] = mo[0];
                    mv[0] = in_valid;
                    md[0] = ref_add(a, b, ci);
                    mo[0] = ref_ovf(a, b, ci);
                end
            end
        end
    end

    // ---------------- directed single transaction ----------------
    task automatic directed(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tci,
                            input logic [W-1:0] es, input logic ec, input logic eo,
                            input string nm);
        int cyc;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        in_valid = 1'b1; a = ta; b = tb_; ci = tci;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        while (cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (out_valid) break;
        end
        chk({nm, "_latency"}, 65'(cyc), 65'(3));
        chk({nm, "_sum"}, 65'(sum), 65'(es));
        chk({nm, "_co"}, 65'(co), 65'(ec));
`ifdef CLA_PIPE_OVF_EN
        chk({nm, "_ovf"}, 65'(ovf), 65'(eo));
`else
        if (eo !== eo) $display("unreachable");
`endif
    endtask

    // ---------------- main stimulus ----------------
    logic [W-1:0] tab_a [6] = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h0000, 16'h5555};
    logic [W-1:0] tab_b [6] = '{16'h0001, 16'h0000, 16'h8000, 16'hFFFF, 16'h0000, 16'hAAAA};
    logic         tab_c [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 65'(in_ready), 65'(1));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // wrap-around and full carry chain, hand-computed
        directed(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "wrap");
        directed(16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1, "chain");

        // corner table streamed back to back
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; out_ready = 1'b1;
            a = tab_a[i]; b = tab_b[i]; ci = tab_c[i];
        end

        // 100 random pairs back to back
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; out_ready = 1'b1;
            a = W'($urandom); b = W'($urandom); ci = 1'($urandom);
        end

        // random handshake on both sides
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            a = W'($urandom); b = W'($urandom); ci = 1'($urandom);
        end

        // fill the pipe, then stall for 5 cycles
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; out_ready = 1'b1;
            a = W'($urandom); b = W'($urandom); ci = 1'($urandom);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        a = W'($urandom); b = W'($urandom);
        repeat (5) begin
            @(negedge clk);
            chk("stall_in_ready", 65'(in_ready), 65'(0));
            chk("stall_out_valid", 65'(out_valid), 65'(1));
        end
        @(posedge clk); #1;
        out_ready = 1'b1; in_valid = 1'b0;
        repeat (5) @(posedge clk);

        // reset with three results in flight
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; out_ready = 1'b1;
            a = W'($urandom); b = W'($urandom); ci = 1'($urandom);
        end
        @(posedge clk); #1;
        chk("pre_rst_out_valid", 65'(out_valid), 65'(1));
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 65'(out_valid), 65'(0));
        chk("async_rst_in_ready", 65'(in_ready), 65'(1));
        chk("async_rst_sum", 65'(sum), 65'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        directed(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, "post_rst");

        // parameter sweep: all-ones + 0 + 1
        @(posedge clk); #1;
        sw_valid = 1'b1;
        @(posedge clk); #1;
        sw_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("sw8_valid", 65'(sw8_v), 65'(1));
        chk("sw8_sum", 65'(sw8_sum), 65'(0));
        chk("sw8_co", 65'(sw8_co), 65'(1));
        chk("sw8_ready", 65'(sw8_rdy), 65'(1));
        chk("sw32_valid", 65'(sw32_v), 65'(1));
        chk("sw32_sum", 65'(sw32_sum), 65'(0));
        chk("sw32_co", 65'(sw32_co), 65'(1));
        chk("sw32_ready", 65'(sw32_rdy), 65'(1));
        chk("sw64_valid", 65'(sw64_v), 65'(1));
        chk("sw64_sum", 65'(sw64_sum), 65'(0));
        chk("sw64_co", 65'(sw64_co), 65'(1));
        chk("sw64_ready", 65'(sw64_rdy), 65'(1));
`ifdef CLA_PIPE_OVF_EN
        chk("sw8_ovf", 65'(sw8_ovf), 65'(0));
        chk("sw32_ovf", 65'(sw32_ovf), 65'(0));
        chk("sw64_ovf", 65'(sw64_ovf), 65'(0));
`endif
        @(negedge clk);
        chk("sw8_valid_drop", 65'(sw8_v), 65'(0));
        chk("sw64_valid_drop", 65'(sw64_v), 65'(0));

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
